stopwatch_bcd_counter: RTL and testbench
========================================

// Module: stopwatch_bcd_counter
// PURPOSE
//  Consumes the 1 Hz square wave from the 1 Hz generator stage (same clk_50MHz domain, registered).
//  Rising-edge detects it, counts elapsed MM:SS in BCD under start/stop/clear control.
//  Feeds the seven-segment display driver with four BCD digits and status pulses.
// PARAMETERS
//  MAX_MINUTES  59  highest minute value before wrap; legal range 1..99
// PORTS
//  clk_50MHz   in   1  system clock; the only clock
//  reset       in   1  synchronous, active-high
//  clk_1Hz     in   1  1 Hz square wave from upstream generator, synchronous to clk_50MHz
//  start_stop  in   1  one-cycle pulse: run/pause toggle
//  clear       in   1  one-cycle pulse: zero count, stop
//  sec_ones    out  4  BCD 0..9
//  sec_tens    out  4  BCD 0..5
//  min_ones    out  4  BCD 0..9
//  min_tens    out  4  BCD 0..9 (bounded by MAX_MINUTES)
//  running     out  1  high in RUN
//  tick_out    out  1  one-cycle pulse per counted second
//  rollover    out  1  one-cycle pulse on MAX_MINUTES:59 -> 00:00
// BEHAVIOUR
//  Reset: all digits 0, running 0, tick_out 0, rollover 0, state IDLE.
//  Edge detect: clk_1Hz_q captures clk_1Hz every cycle, including reset cycles (no spurious edge
//   after reset release). edge = clk_1Hz & ~clk_1Hz_q.
//  FSM states IDLE, RUN, PAUSE. start_stop: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
//   clear: any state -> IDLE, digits 0 next cycle. clear wins over start_stop and edge same cycle.
//  Count: increments only when current (registered) state is RUN and edge=1.
//   Edge coincident with pause pulse in RUN: counted. Edge coincident with resume in PAUSE: not counted.
//  Latency: edge detected in cycle N -> digits updated, tick_out=1 in cycle N+1; all outputs registered.
//  Carry chain: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones;
//   min_ones 9->0 carries to min_tens. At MAX_MINUTES:59 next tick -> 00:00, rollover=1 with tick_out.
//  Counting continues after rollover (no stop). Digits never hold a non-BCD value.
//  running = (state==RUN), registered with state.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined: adds input port lap (1-bit pulse). lap in RUN toggles display freeze;
//   frozen outputs show count captured at lap pulse while internal count advances; second lap
//   unfreezes. clear or reset unfreezes. lap ignored in IDLE/PAUSE. tick_out/rollover unaffected.
//  Not defined: no lap port; digit outputs always show live count.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/RUN/PAUSE), BCD digit width 4, SEC_TENS_MAX=5,
//   DIGIT_MAX=9.
//  Sub-module bcd_digit: one BCD digit with inc, clear, max-value input, carry-out (4 instances).
// TESTING
//  Bench drives clk_1Hz directly with short period (e.g. 8 clk_50MHz cycles) for speed.
//  1 reset high with clk_1Hz=1, release -> no tick_out, digits 00:00, running 0.
//  2 start_stop, 12 clk_1Hz rising edges -> 00:12, 12 tick_out pulses, each 1 cycle after edge.
//  3 preload to 00:59 via ticks, one edge -> 01:00; continue to MAX_MINUTES:59, one edge -> 00:00,
//    rollover=1 for exactly that cycle.
//  4 pause at 00:05, 3 edges -> holds 00:05; resume pulse same cycle as edge -> edge not counted;
//    pause pulse same cycle as edge in RUN -> counted.
//  5 clear + start_stop + edge same cycle at 03:27 -> 00:00, IDLE, running 0, no tick_out.
//  6 STOPWATCH_LAP_EN: lap at 00:10, 5 edges -> outputs 00:10, lap again -> 00:15; clear while frozen
//    -> 00:00 live.

Source files
------------

// File: rtl/stopwatch_bcd_counter_pkg.sv
// rtl/stopwatch_bcd_counter_pkg.sv - shared state encoding and BCD constants for the stopwatch
package stopwatch_bcd_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t DIGIT_MAX    = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Run/pause toggle: IDLE and PAUSE both go to RUN, RUN goes to PAUSE.
  function automatic state_t next_on_toggle(input state_t s);
    case (s)
      IDLE:    return RUN;
      RUN:     return PAUSE;
      PAUSE:   return RUN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// rtl/stopwatch_bcd_counter_if.sv - control inputs and display outputs of the stopwatch (lap port under STOPWATCH_LAP_EN)
interface stopwatch_bcd_counter_if;
  import stopwatch_bcd_counter_pkg::*;

  logic clk_1Hz;
  logic start_stop;
  logic clear;
`ifdef STOPWATCH_LAP_EN
  logic lap;
`endif
  bcd_t sec_ones;
  bcd_t sec_tens;
  bcd_t min_ones;
  bcd_t min_tens;
  logic running;
  logic tick_out;
  logic rollover;

`ifdef STOPWATCH_LAP_EN
  modport master (
    output clk_1Hz, start_stop, clear, lap,
    input  sec_ones, sec_tens, min_ones, min_tens, running, tick_out, rollover
  );
  modport slave (
    input  clk_1Hz, start_stop, clear, lap,
    output sec_ones, sec_tens, min_ones, min_tens, running, tick_out, rollover
  );
`else
  modport master (
    output clk_1Hz, start_stop, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, running, tick_out, rollover
  );
  modport slave (
    input  clk_1Hz, start_stop, clear,
    output sec_ones, sec_tens, min_ones, min_tens, running, tick_out, rollover
  );
`endif

endinterface

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// rtl/stopwatch_bcd_counter_bcd_digit.sv - one BCD digit with increment, clear and carry-out
module stopwatch_bcd_counter_bcd_digit
  import stopwatch_bcd_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  bcd_t max_value,
  output bcd_t value,
  output logic carry
);

  // Carry fires on the increment that wraps this digit; >= keeps a stray value from escaping BCD.
  assign carry = inc && (value >= max_value);

  // Digit register: clear beats increment, wrap to zero past max_value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= carry ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// rtl/stopwatch_bcd_counter.sv - MM:SS BCD stopwatch with run/pause/clear control; STOPWATCH_LAP_EN adds lap freeze
module stopwatch_bcd_counter
  import stopwatch_bcd_counter_pkg::*;
#(
  parameter int MAX_MINUTES = 59
) (
  input logic                    clk_50MHz,
  input logic                    reset,
  stopwatch_bcd_counter_if.slave bus
);

  localparam bcd_t MIN_TENS_LAST = bcd_t'(MAX_MINUTES / 10);
  localparam bcd_t MIN_ONES_LAST = bcd_t'(MAX_MINUTES % 10);

  state_t state;
  state_t next_state;
  logic   clk_1Hz_q;
  logic   one_hz_edge;
  logic   count_en;
  logic   wrap;
  logic   c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;
  bcd_t   live_sec_ones, live_sec_tens, live_min_ones, live_min_tens;
  logic   tick_q;
  logic   rollover_q;

  // Delayed copy of the 1 Hz wave; also loads during reset so release never looks like an edge.
  always_ff @(posedge clk_50MHz) begin
    clk_1Hz_q <= bus.clk_1Hz;
  end

  assign one_hz_edge = bus.clk_1Hz & ~clk_1Hz_q;
  assign count_en    = (state == RUN) && one_hz_edge && !bus.clear;

  // State register.
  always_ff @(posedge clk_50MHz) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state: clear dominates the run/pause toggle.
  always_comb begin
    next_state = state;
    if (bus.clear)           next_state = IDLE;
    else if (bus.start_stop) next_state = next_on_toggle(state);
  end

  // Last count is MAX_MINUTES:59; c_min_tens covers the 99:59 case where the chain itself overflows.
  assign wrap = c_sec_tens &&
                (((live_min_ones == MIN_ONES_LAST) && (live_min_tens == MIN_TENS_LAST)) || c_min_tens);

  stopwatch_bcd_counter_bcd_digit u_sec_ones (
    .clk(clk_50MHz), .reset(reset), .clr(bus.clear || wrap), .inc(count_en),
    .max_value(DIGIT_MAX), .value(live_sec_ones), .carry(c_sec_ones)
  );
  stopwatch_bcd_counter_bcd_digit u_sec_tens (
    .clk(clk_50MHz), .reset(reset), .clr(bus.clear || wrap), .inc(c_sec_ones),
    .max_value(SEC_TENS_MAX), .value(live_sec_tens), .carry(c_sec_tens)
  );
  stopwatch_bcd_counter_bcd_digit u_min_ones (
    .clk(clk_50MHz), .reset(reset), .clr(bus.clear || wrap), .inc(c_sec_tens),
    .max_value(DIGIT_MAX), .value(live_min_ones), .carry(c_min_ones)
  );
  stopwatch_bcd_counter_bcd_digit u_min_tens (
    .clk(clk_50MHz), .reset(reset), .clr(bus.clear || wrap), .inc(c_min_ones),
    .max_value(DIGIT_MAX), .value(live_min_tens), .carry(c_min_tens)
  );

  // Status pulses land in the same cycle as the digit update they describe.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      tick_q     <= count_en;
      rollover_q <= wrap;
    end
  end

  assign bus.tick_out = tick_q;
  assign bus.rollover = rollover_q;
  assign bus.running  = (state == RUN);

`ifdef STOPWATCH_LAP_EN
  logic frozen;
  bcd_t snap_sec_ones, snap_sec_tens, snap_min_ones, snap_min_tens;
  logic lap_hit;

  assign lap_hit = bus.lap && (state == RUN) && !bus.clear;

  // Lap toggles the freeze; entering freeze captures the count as it stood before this cycle's tick.
  always_ff @(posedge clk_50MHz) begin
    if (reset || bus.clear) begin
      frozen <= 1'b0;
    end else if (lap_hit) begin
      frozen <= ~frozen;
      if (!frozen) begin
        snap_sec_ones <= live_sec_ones;
        snap_sec_tens <= live_sec_tens;
        snap_min_ones <= live_min_ones;
        snap_min_tens <= live_min_tens;
      end
    end
  end

  assign bus.sec_ones = frozen ? snap_sec_ones : live_sec_ones;
  assign bus.sec_tens = frozen ? snap_sec_tens : live_sec_tens;
  assign bus.min_ones = frozen ? snap_min_ones : live_min_ones;
  assign bus.min_tens = frozen ? snap_min_tens : live_min_tens;
`else
  assign bus.sec_ones = live_sec_ones;
  assign bus.sec_tens = live_sec_tens;
  assign bus.min_ones = live_min_ones;
  assign bus.min_tens = live_min_tens;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb/tb_stopwatch_bcd_counter.sv - self-checking bench for stopwatch_bcd_counter (lap test under STOPWATCH_LAP_EN)
module tb_stopwatch_bcd_counter;

  localparam int MAX_MIN   = 59;
  localparam int WRAP_SECS = (MAX_MIN + 1) * 60;

  typedef struct {
    logic [15:0] digits;
    logic        roll;
    int          cyc;
  } exp_t;

  logic clk_50MHz = 1'b0;
  logic reset;
  stopwatch_bcd_counter_if bus();

  stopwatch_bcd_counter #(.MAX_MINUTES(MAX_MIN)) dut (
    .clk_50MHz(clk_50MHz),
    .reset(reset),
    .bus(bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_cnt = 0;
  int   roll_seen = 0;
  int   tick_seen = 0;
  int   m_state = 0;
  int   m_total = 0;
  int   m_snap = 0;
  bit   m_frozen = 1'b0;
  logic [15:0] shown;

  assign shown = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};

  always @(posedge clk_50MHz) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] to_bcd(input int t);
    int mm;
    int ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Scoreboard consumer: every tick_out must match the oldest expected tick.
  always @(negedge clk_50MHz) begin
    if (bus.rollover === 1'b1) begin
      checks++;
      roll_seen++;
      if (bus.tick_out !== 1'b1) begin
        errors++;
        $display("FAIL rollover_without_tick: tick_out=%b required 1", bus.tick_out);
      end
    end
    if (bus.tick_out === 1'b1) begin
      tick_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: digits=%h at cycle %0d, no tick required", shown, cyc_cnt);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (shown !== x.digits || bus.rollover !== x.roll || cyc_cnt != x.cyc) begin
          errors++;
          $display("FAIL tick: digits=%h roll=%b cycle=%0d required digits=%h roll=%b cycle=%0d",
                   shown, bus.rollover, cyc_cnt, x.digits, x.roll, x.cyc);
        end
      end
    end
  end

  task automatic model_step(input bit e, input bit ss, input bit clr, input bit lp);
    exp_t x;
    if (clr) begin
      m_state  = 0;
      m_total  = 0;
      m_frozen = 1'b0;
    end else begin
      if (lp && m_state == 1) begin
        if (!m_frozen) m_snap = m_total;
        m_frozen = !m_frozen;
      end
      if (e && m_state == 1) begin
        x.roll   = (m_total == WRAP_SECS - 1);
        m_total  = (m_total + 1) % WRAP_SECS;
        x.digits = to_bcd(m_frozen ? m_snap : m_total);
        x.cyc    = cyc_cnt + 1;
        sb.push_back(x);
      end
      if (ss) m_state = (m_state == 1) ? 2 : 1;
    end
  endtask

  // One stimulus slot; with e=1 it is a full 8-cycle period of clk_1Hz starting with the rising edge.
  task automatic drive(input bit e, input bit ss, input bit clr, input bit lp);
    @(posedge clk_50MHz); #1;
    bus.clk_1Hz    = e;
    bus.start_stop = ss;
    bus.clear      = clr;
`ifdef STOPWATCH_LAP_EN
    bus.lap        = lp;
`endif
    model_step(e, ss, clr, lp);
    @(posedge clk_50MHz); #1;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    bus.lap        = 1'b0;
`endif
    if (e) begin
      repeat (3) begin @(posedge clk_50MHz); #1; end
      bus.clk_1Hz = 1'b0;
      repeat (3) begin @(posedge clk_50MHz); #1; end
    end
  endtask

  task automatic edges(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset          = 1'b1;
    bus.clk_1Hz    = 1'b1;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    bus.lap        = 1'b0;
`endif
    repeat (4) @(posedge clk_50MHz);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50MHz);
      checks++;
      if (bus.tick_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_tick: tick_out=%b required 0", bus.tick_out);
      end
    end
    checks++;
    if (shown !== 16'h0000 || bus.running !== 1'b0 || bus.rollover !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits=%h running=%b rollover=%b required 0000 0 0",
               shown, bus.running, bus.rollover);
    end
    @(posedge clk_50MHz); #1 bus.clk_1Hz = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    edges(1);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0000) begin
      errors++;
      $display("FAIL idle_edge: digits=%h required 0000", shown);
    end
  endtask

  task automatic test_count;
    int t0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    t0 = tick_seen;
    edges(12);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0012 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL count_12: digits=%h running=%b required 0012 1", shown, bus.running);
    end
    checks++;
    if (tick_seen - t0 != 12) begin
      errors++;
      $display("FAIL tick_count: got %0d ticks required 12", tick_seen - t0);
    end
  endtask

  task automatic test_rollover;
    edges(47);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0059) begin
      errors++;
      $display("FAIL at_0059: digits=%h required 0059", shown);
    end
    edges(1);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0100) begin
      errors++;
      $display("FAIL carry_0100: digits=%h required 0100", shown);
    end
    edges(WRAP_SECS - 1 - 60);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h5959 || roll_seen != 0) begin
      errors++;
      $display("FAIL at_5959: digits=%h rollovers=%0d required 5959 0", shown, roll_seen);
    end
    edges(1);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0000 || roll_seen != 1 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL wrap: digits=%h rollovers=%0d running=%b required 0000 1 1",
               shown, roll_seen, bus.running);
    end
    edges(1);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0001 || roll_seen != 1) begin
      errors++;
      $display("FAIL after_wrap: digits=%h rollovers=%0d required 0001 1", shown, roll_seen);
    end
  endtask

  task automatic test_pause;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    edges(5);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_50MHz);
    checks++;
    if (bus.running !== 1'b0) begin
      errors++;
      $display("FAIL paused_running: running=%b required 0", bus.running);
    end
    edges(3);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0005) begin
      errors++;
      $display("FAIL pause_hold: digits=%h required 0005", shown);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0005 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL resume_edge: digits=%h running=%b required 0005 1", shown, bus.running);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0006 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL pause_edge: digits=%h running=%b required 0006 0", shown, bus.running);
    end
  endtask

  task automatic test_clear_priority;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    edges(207);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0327) begin
      errors++;
      $display("FAIL at_0327: digits=%h required 0327", shown);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0000 || bus.running !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL clear_wins: digits=%h running=%b pending=%0d required 0000 0 0",
               shown, bus.running, sb.size());
    end
    edges(1);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0000) begin
      errors++;
      $display("FAIL idle_after_clear: digits=%h required 0000", shown);
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    edges(10);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    edges(5);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0010) begin
      errors++;
      $display("FAIL lap_frozen: digits=%h required 0010", shown);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0015) begin
      errors++;
      $display("FAIL lap_release: digits=%h required 0015", shown);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    edges(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0000 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL lap_clear: digits=%h running=%b required 0000 0", shown, bus.running);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    edges(1);
    @(negedge clk_50MHz);
    checks++;
    if (shown !== 16'h0001) begin
      errors++;
      $display("FAIL lap_live_after_clear: digits=%h required 0001", shown);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_pause();
    test_clear_priority();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    repeat (4) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_ticks: %0d expected ticks never seen, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
